// File: rtl/edge_frame_pkg.sv
// Shared constants and types for the edge-detector frame reader.
// Frame geometry, pixel encodings and the readout FSM state type.
package edge_frame_pkg;

    localparam int unsigned FRAME_W      = 64;
    localparam int unsigned FRAME_H      = 64;
    localparam int unsigned FRAME_PIXELS = FRAME_W * FRAME_H;

    localparam logic [7:0] PIX_ON  = 8'hFF;
    localparam logic [7:0] PIX_OFF = 8'h00;

    typedef enum logic [1:0] {
        StFill,
        StRd,
        StOut
    } state_e;

endpackage

// File: rtl/edge_frame_ram.sv
// One-bit-wide frame store: synchronous write port, synchronous registered read port.
// The array has no reset; contents persist across frames.
module edge_frame_ram #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned AddrW = 12
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic             wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic             rd_data_o
);

    logic mem_q [Depth];
    logic rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read data only updates on a read, so it stays stable while a beat is stalled.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/edge_frame_reader.sv
// Captures per-pixel edge bits into a one-bit frame store and, on frame_done,
// streams the frame back in raster order as grey pixels over valid/ready.
module edge_frame_reader #(
    parameter int unsigned FRAME_W = edge_frame_pkg::FRAME_W,
    parameter int unsigned FRAME_H = edge_frame_pkg::FRAME_H,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned PIX_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       wr_data,
    input  logic                       frame_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX_W-1:0]           out_data,
    output logic [$clog2(FRAME_W)-1:0] out_x,
    output logic [$clog2(FRAME_H)-1:0] out_y,
    output logic                       out_last,
    output logic                       busy,
    output logic                       addr_err,
    output logic                       drop_err
);

    import edge_frame_pkg::*;

    localparam int unsigned XW    = $clog2(FRAME_W);
    localparam int unsigned YW    = $clog2(FRAME_H);
    localparam int unsigned CNT_W = XW + YW;
    localparam int unsigned NPIX  = FRAME_W * FRAME_H;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic               addr_err_q, addr_err_d;
    logic               drop_err_q, drop_err_d;

    logic               ram_we;
    logic               ram_re;
    logic               ram_rd_bit;
    logic               wr_in_range;
    logic               cnt_at_end;

    // Any set bit above the frame index range makes the address out of range.
    assign wr_in_range = ((wr_addr >> CNT_W) == '0);
    assign cnt_at_end  = &rd_cnt_q;

    edge_frame_ram #(
        .Depth (NPIX),
        .AddrW (CNT_W)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_addr[CNT_W-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (ram_rd_bit)
    );

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        addr_err_d = addr_err_q;
        drop_err_d = drop_err_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            StFill: begin
                if (wr_en) begin
                    if (wr_in_range) begin
                        ram_we = 1'b1;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                // A write in the same cycle commits before the first read is issued.
                if (frame_done) begin
                    state_d  = StRd;
                    rd_cnt_d = '0;
                end
            end
            StRd: begin
                ram_re  = 1'b1;
                state_d = StOut;
                if (wr_en || frame_done) begin
                    drop_err_d = 1'b1;
                end
            end
            StOut: begin
                if (wr_en || frame_done) begin
                    drop_err_d = 1'b1;
                end
                if (out_ready) begin
                    if (cnt_at_end) begin
                        state_d = StFill;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = StRd;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFill;
            rd_cnt_q   <= '0;
            addr_err_q <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            addr_err_q <= addr_err_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_comb begin
        out_valid = (state_q == StOut);
        out_data  = (out_valid && ram_rd_bit) ? PIX_W'(PIX_ON) : PIX_W'(PIX_OFF);
        out_x     = rd_cnt_q[XW-1:0];
        out_y     = rd_cnt_q[CNT_W-1:XW];
        out_last  = out_valid && cnt_at_end;
        busy      = (state_q == StRd) || (state_q == StOut);
        addr_err  = addr_err_q;
        drop_err  = drop_err_q;
    end

endmodule

// File: tb/tb_edge_frame_reader.sv
// Directed bench for edge_frame_reader: frame fill, raster readout, backpressure,
// error flags, same-cycle write/frame_done and mid-readout reset.
module tb_edge_frame_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [12:0] wr_addr = '0;
    logic        wr_data = 1'b0;
    logic        frame_done = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [5:0]  out_x;
    logic [5:0]  out_y;
    logic        out_last;
    logic        busy;
    logic        addr_err;
    logic        drop_err;

    int n_pass  = 0;
    int n_total = 0;
    int now_cyc = 0;
    bit model [4096];

    edge_frame_reader #(
        .FRAME_W (64),
        .FRAME_H (64),
        .ADDR_W  (13),
        .PIX_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .busy       (busy),
        .addr_err   (addr_err),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic write_px(input int addr, input bit data);
        wr_en   = 1'b1;
        wr_addr = addr[12:0];
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Called one cycle after frame_done; drains beats until stop_beat is presented
    // (or the whole frame when stop_beat < 0). inject_cyc pulses wr_en/frame_done.
    task automatic drain(input int ready_pct, input int stop_beat, input int inject_cyc,
                         input bit check_timing);
        int          beat = 0;
        int          cyc  = 0;
        bit          done = 0;
        logic [11:0] b;
        logic [20:0] exp;
        while (!done) begin
            if (cyc > 40000) begin
                check("drain_timeout", beat, 4096);
                done = 1;
            end else begin
                wr_en      = (cyc == inject_cyc);
                frame_done = (cyc == inject_cyc);
                wr_addr    = '0;
                wr_data    = ~model[0];
                if (out_valid) begin
                    b   = beat[11:0];
                    exp = {(model[b] ? 8'hFF : 8'h00), b[5:0], b[11:6], (b == 12'hFFF)};
                    check("beat", {out_data, out_x, out_y, out_last}, exp);
                    if (beat == stop_beat) done = 1;
                end
                if (!done) begin
                    out_ready = ($urandom_range(99) < ready_pct);
                    if (out_valid && out_ready) beat++;
                    step();
                    cyc++;
                    now_cyc++;
                    if (beat == 4096) done = 1;
                end
            end
        end
        wr_en      = 1'b0;
        frame_done = 1'b0;
        out_ready  = 1'b0;
        if (stop_beat < 0) begin
            check("end_busy", busy, 0);
            check("end_valid", out_valid, 0);
            if (check_timing) check("frame_cycles", now_cyc, 8193);
        end
    endtask

    initial begin
        // Reset values
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_x", out_x, 0);
        check("rst_y", out_y, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_drop_err", drop_err, 0);
        reset = 1'b0;
        step();

        // Checkerboard frame, out_ready held high
        for (int i = 0; i < 4096; i++) begin
            wr_en    = 1'b1;
            wr_addr  = i[12:0];
            wr_data  = ((i & 63) ^ (i >> 6)) & 1;
            model[i] = wr_data;
            step();
        end
        wr_en      = 1'b0;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        now_cyc    = 1;
        check("fd_busy", busy, 1);
        check("fd_valid", out_valid, 0);
        drain(100, -1, -1, 1'b1);
        check("cb_addr_err", addr_err, 0);
        check("cb_drop_err", drop_err, 0);

        // Zero frame with a single set pixel, out-of-range writes, backpressure, drops
        for (int i = 0; i < 4096; i++) begin
            wr_en    = 1'b1;
            wr_addr  = i[12:0];
            wr_data  = 1'b0;
            model[i] = 1'b0;
            step();
        end
        wr_en = 1'b0;
        write_px(130, 1'b1);
        model[130] = 1'b1;
        write_px(4096, 1'b1);
        write_px(8191, 1'b1);
        check("oor_addr_err", addr_err, 1);
        check("oor_drop_err", drop_err, 0);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        now_cyc    = 1;
        drain(30, -1, 20, 1'b0);
        check("bp_drop_err", drop_err, 1);
        check("bp_addr_err", addr_err, 1);

        // Same-cycle write and frame_done, then reset at beat 100
        wr_en      = 1'b1;
        wr_addr    = '0;
        wr_data    = 1'b1;
        frame_done = 1'b1;
        model[0]   = 1'b1;
        step();
        wr_en      = 1'b0;
        frame_done = 1'b0;
        now_cyc    = 1;
        step();
        check("same_cyc_first", out_data, 8'hFF);
        drain(100, 100, -1, 1'b0);
        check("b100_x", out_x, 36);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr_err", addr_err, 0);
        check("mid_rst_drop_err", drop_err, 0);
        check("mid_rst_x", out_x, 0);
        check("mid_rst_y", out_y, 0);
        check("mid_rst_data", out_data, 0);

        // Restart after reset: RAM kept, readout from pixel 0
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        check("restart_busy", busy, 1);
        step();
        check("restart_valid", out_valid, 1);
        check("restart_xy", {out_x, out_y}, 12'h000);
        check("restart_data", out_data, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/edge_frame_reader.md
# edge_frame_reader

Sink-side frame buffer for the Sobel edge detector's output stream. Captures the detector's per-pixel edge bits, written by 13-bit address, into a 64x64 one-bit frame store. On a frame-done strobe it reads the whole frame back in raster order as 8-bit grey pixels over a valid/ready stream. Sits between the `sobel` core and any downstream consumer (display scanout, UART dump, checker).

## Interface
Parameters:
- FRAME_W, 64, pixels per line (power of two)
- FRAME_H, 64, lines per frame (power of two)
- ADDR_W, 13, width of write address, matches the `sobel` address output
- PIX_W, 8, output pixel width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe from edge detector
- wr_addr  in  ADDR_W  pixel address, linear raster (y*FRAME_W + x)
- wr_data  in  1  edge bit
- frame_done  in  1  one-cycle strobe: frame complete, begin readout
- out_valid  out  1  out_data/out_x/out_y/out_last valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_data  out  PIX_W  8'hFF for edge bit 1, 8'h00 for 0
- out_x  out  6  column of current pixel
- out_y  out  6  line of current pixel
- out_last  out  1  high with the final pixel (x=63, y=63)
- busy  out  1  high while in readout
- addr_err  out  1  sticky: write with wr_addr >= 4096 seen
- drop_err  out  1  sticky: write or frame_done arrived during readout

## Operation
- States: FILL, RD, OUT. Reset enters FILL.
- FILL: wr_en writes wr_data to RAM[wr_addr[11:0]] when wr_addr < 4096; out-of-range writes discarded, addr_err set. frame_done -> RD, read counter cleared to 0.
- Same-cycle wr_en and frame_done in FILL: write commits, then readout starts; the written pixel is visible in the readout.
- RD: issue synchronous RAM read at rd_cnt; next state OUT.
- OUT: out_valid=1, out_data from RAM, out_x=rd_cnt[5:0], out_y=rd_cnt[11:6], out_last=(rd_cnt==4095). All held stable until accepted.
- OUT with out_valid & out_ready: if out_last -> FILL, else rd_cnt+1 -> RD.
- busy=1 in RD and OUT.
- During RD/OUT: wr_en and frame_done ignored, drop_err set. RAM is not modified.
- RAM is never cleared; pixels not rewritten in a frame keep their previous value (content after reset is undefined).
- addr_err and drop_err are cleared only by reset.

## Timing
- Reset values: out_valid 0, out_data 0, out_x 0, out_y 0, out_last 0, busy 0, addr_err 0, drop_err 0, rd_cnt 0, state FILL.
- Write latency: a write at cycle T is readable by a read issued at T+1.
- frame_done at T -> busy=1 at T+1 (RD) -> out_valid=1 at T+2 with pixel 0.
- Handshake at cycle k (not last) -> out_valid=0 at k+1 -> next pixel valid at k+2. Peak throughput is 1 pixel per 2 cycles. A full frame with out_ready tied high takes 8192 cycles from the first RD.
- Last pixel accepted at k -> FILL at k+1, busy=0 at k+1, writes accepted from k+1.
- out_ready low: outputs held, no state change, no limit on stall length.
- Reset mid-readout: next cycle FILL, outputs at reset values, sticky flags cleared.

## Structure
- Package edge_frame_pkg: FRAME_W, FRAME_H, FRAME_PIXELS=4096, PIX_ON=8'hFF, PIX_OFF=8'h00, state enum {FILL, RD, OUT}.
- Sub-module edge_frame_ram: 4096x1, one synchronous write port, one synchronous read port (registered output), no reset on the array.
- Top holds the FSM, rd_cnt, coordinate decode, and sticky flags.

## Test plan
- Write a checkerboard ((x^y)&1) to all 4096 addresses, pulse frame_done, out_ready=1 -> 4096 beats in raster order, data alternating 00/FF per the pattern, out_last only on beat 4095 (x=63,y=63), busy low 8193 cycles after frame_done.
- Write only address 130 = 1 (after a frame of zeros), drain -> only beat x=2,y=2 is FF.
- Random out_ready backpressure (30% high) -> outputs stable while stalled, no lost or duplicated beats, order intact.
- Write addr 4096 and 8191 in FILL -> addr_err=1, RAM unchanged. Pulse wr_en and frame_done during readout -> drop_err=1, readout data unchanged.
- Same-cycle wr_en(addr 0, data 1) with frame_done -> first beat is FF.
- Assert reset at beat 100 of readout -> next cycle out_valid=0, busy=0, flags 0. A new frame_done restarts readout at x=0,y=0.
